rgb_pwm_generator: RTL
======================

# rgb_pwm_generator

Three-channel PWM generator that drives the R, G and B LED pins from 8-bit duty values. It sits downstream of the state-to-duty decoder and consumes its `R/G/B_time_out` values directly. A single free-running period counter is shared by all three channels. Duty values are shadow-latched once per period, so a duty change never glitches a period already in progress.

## Interface
- `DIV`, default 1: clock cycles per PWM tick (prescaler). Legal range is ≥1; prescaler width is `$clog2(DIV)`, minimum 1 bit.
- `clk  input  1`: sole clock, rising edge.
- `rst  input  1`: reset, synchronous and active-high.
- `en  input  1`: count enable. Low freezes the counters and forces the outputs low.
- `R_time_in  input  8`: red duty, 0x00 = 0 %, 0xFF = 100 %.
- `G_time_in  input  8`: green duty, same encoding.
- `B_time_in  input  8`: blue duty, same encoding.
- `R_pwm  output  1`: red PWM, registered.
- `G_pwm  output  1`: green PWM, registered.
- `B_pwm  output  1`: blue PWM, registered.
- `period_done  output  1`: single-cycle pulse on the last tick of each period, registered.

## Operation
- Prescaler `presc` counts 0..DIV-1 while `en`=1. `tick` = `en` && `presc`==DIV-1. `presc` wraps to 0 on `tick`.
- Period counter `cnt` counts 0..254 (PWM_PERIOD = 255 ticks). It increments on `tick` and wraps 254→0.
- Load condition `ld` = `en` && `cnt`==0 && `presc`==0, which is the first clock of each period.
- When `ld`=1, shadow registers `R_sh`/`G_sh`/`B_sh` load the `*_time_in` values. Otherwise they hold.
- Effective duty `d_eff` = `*_time_in` when `ld`=1, else `*_sh`. New duty therefore applies from tick 0 of the period.
- Channel compare `raw` = `cnt` < `d_eff` (unsigned, 8-bit).
  - 0x00 gives never high.
  - 0xFF gives always high, since `cnt` ≤ 254.
  - Duty N gives exactly N high ticks per period.
- Output register: `*_pwm` ≤ `en` ? `raw` : 0.
- `period_done` ≤ `tick` && `cnt`==254.
- `en`=0:
  - `presc`, `cnt` and shadows hold.
  - `*_pwm` go 0 next cycle; `period_done` is 0.
  - On re-enable, counting resumes mid-period with the held shadow. No reload occurs unless at `cnt`=0 and `presc`=0.
- Input changes mid-period are ignored until the next `ld`.
- No FSM beyond the counters. All state is `presc`, `cnt` and three 8-bit shadows.

## Timing
- Reset values: `presc`=0, `cnt`=0, shadows=0x00, all `*_pwm`=0, `period_done`=0.
- `rst` has priority over `en` and over everything else, including in mid-period.
- The first cycle after `rst` falls with `en`=1 is a load cycle. The inputs present on that cycle set the first period.
- Latency: one clock from counter state and inputs to `*_pwm`.
  - The first high output appears on the cycle after the load cycle, provided duty > 0.
- Period length is 255·DIV clocks. High time is N·DIV clocks per period.
- `period_done` is high for exactly one clock per period. It rises together with the `*_pwm` value for `cnt`=254.
- With DIV=1, `tick` is high every enabled cycle and `presc` is a constant 0.

## Structure
- Shared package `pwm_pkg`:
  - `DUTY_W`=8.
  - `PWM_PERIOD`=255.
  - `PWM_CNT_MAX`=254.
  - An RGB duty struct/typedef shared with the decoder.
- Sub-module `pwm_channel`:
  - Contains the shadow register, the `d_eff` mux, the comparator and the output flop.
  - Instantiated three times.
  - Ports: `clk`, `rst`, `en`, `ld`, `cnt`, `duty_in`, `pwm`.
- The top level holds `presc`, `cnt` and `period_done`.

## Test plan
- Reset, DIV=1, en=1, inputs R=0xFF/G=0x61/B=0x00, one period:
  - `R_pwm` high all 255 cycles from cycle 1.
  - `G_pwm` high 97 cycles, then low 158.
  - `B_pwm` never high.
  - `period_done` pulses once at cycle 255.
- DIV=4, R=0x7F/G=0x1F/B=0xFF:
  - Period is 1020 clocks.
  - High times: R 508, G 124, B 1020.
  - `period_done` pulse spacing is 1020.
- Change G from 0x61 to 0x00 at tick 10 of a period:
  - The current period still shows 97 high ticks.
  - The next period shows 0.
- Drop `en` at `cnt`=50 for 20 cycles:
  - All `*_pwm` go 0 the next cycle.
  - `cnt` holds at 50; no `period_done`.
  - After re-enable, the remaining high/low pattern completes unchanged.
- Assert `rst` for 1 cycle at `cnt`=100:
  - All outputs are 0 on the next cycle.
  - `cnt` restarts at 0.
  - Inputs are reloaded on the first post-reset cycle.
- Duty sweep 0x00..0xFF, DIV=1: measured high count per period equals the duty value for every code, with no extra pulses at the period boundary.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared PWM constants and the RGB duty bundle exchanged with the state-to-duty decoder.
// No logic here; only types, sizes and an elaboration-time width helper.
package pwm_pkg;

   localparam int DUTY_W      = 8;
   localparam int PWM_PERIOD  = 255;
   localparam int PWM_CNT_MAX = PWM_PERIOD - 1;

   typedef logic [DUTY_W-1:0] duty_t;

   typedef struct packed {
      duty_t r;
      duty_t g;
      duty_t b;
   } rgb_duty_t;

   // A DIV of 1 still needs a one-bit prescaler register to keep the port widths legal.
   function automatic int presc_width(input int div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM lane: shadow duty latched at period start, compare against the shared counter, registered output.
// Output follows the counter and duty inputs by one clock; forced low while disabled.
module pwm_channel
   import pwm_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              ld,
   input  logic [DUTY_W-1:0] cnt,
   input  logic [DUTY_W-1:0] duty_in,
   output logic              pwm
);

   duty_t sh_q, sh_d;
   duty_t d_eff;
   logic  raw;
   logic  pwm_q, pwm_d;

   // On the load cycle the incoming duty is used directly so tick 0 already reflects it.
   always_comb begin
      d_eff = ld ? duty_in : sh_q;
      sh_d  = d_eff;
      raw   = (cnt < d_eff);
      pwm_d = en & raw;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sh_q  <= '0;
         pwm_q <= 1'b0;
      end else begin
         sh_q  <= sh_d;
         pwm_q <= pwm_d;
      end
   end

   assign pwm = pwm_q;

endmodule

// File: rtl/rgb_pwm_generator.sv
// Three-channel PWM with a shared prescaler and 255-tick period counter; duties are taken once per period.
// Outputs and period_done are registered, one clock behind the counter state; en low freezes counting.
module rgb_pwm_generator
   import pwm_pkg::*;
#(
   parameter int DIV = 1
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [DUTY_W-1:0] R_time_in,
   input  logic [DUTY_W-1:0] G_time_in,
   input  logic [DUTY_W-1:0] B_time_in,
   output logic              R_pwm,
   output logic              G_pwm,
   output logic              B_pwm,
   output logic              period_done
);

   localparam int                 PRESC_W    = presc_width(DIV);
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);
   localparam duty_t              CNT_LAST   = duty_t'(PWM_CNT_MAX);

   logic [PRESC_W-1:0] presc_q, presc_d;
   duty_t              cnt_q, cnt_d;
   logic               done_q, done_d;
   logic               tick;
   logic               ld;
   rgb_duty_t          duty_in;

   assign duty_in = '{r: R_time_in, g: G_time_in, b: B_time_in};

   assign tick = en && (presc_q == PRESC_LAST);
   assign ld   = en && (cnt_q == '0) && (presc_q == '0);

   always_comb begin
      presc_d = presc_q;
      cnt_d   = cnt_q;
      if (tick) begin
         presc_d = '0;
         cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      end else if (en) begin
         presc_d = presc_q + 1'b1;
      end
      done_d = tick && (cnt_q == CNT_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         presc_q <= presc_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   assign period_done = done_q;

   pwm_channel u_ch_r (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .ld      (ld),
      .cnt     (cnt_q),
      .duty_in (duty_in.r),
      .pwm     (R_pwm)
   );

   pwm_channel u_ch_g (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .ld      (ld),
      .cnt     (cnt_q),
      .duty_in (duty_in.g),
      .pwm     (G_pwm)
   );

   pwm_channel u_ch_b (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .ld      (ld),
      .cnt     (cnt_q),
      .duty_in (duty_in.b),
      .pwm     (B_pwm)
   );

endmodule
